lcd_init_sequencer: RTL and testbench

- Sequences the LCD panel from power-up to pixel streaming. It drives the hardware reset pulse, then issues the panel init command/data byte list through the shared lcd_write serializer. It then opens a full-screen write window and raises init_done.
- After init, it hands the lcd_write port to the spectrum display client via a pass-through mux.
- Sits between lcd_spectrum_display and lcd_write, in the 50 MHz domain.

---
 rtl/lcd_init_sequencer_if.sv | 9 +
 rtl/lcd_init_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_init_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_init_sequencer_if.sv
// Byte-write handshake toward lcd_write: 9-bit word (bit8 = D/C), enable, one-cycle completion pulse.
interface lcd_init_sequencer_if;
    logic [8:0] data;
    logic       en;
    logic       wr_done;

    modport master (output data, output en, input wr_done);
    modport slave  (input data, input en, output wr_done);
endinterface

// File: rtl/lcd_init_sequencer.sv
// LCD power-up sequencer: reset pulse, init command list, full-screen window, then client pass-through.
// Optional LCD_WIN_RESET_EN adds frame_start to re-issue the window sub-list from RUN.
module lcd_init_sequencer #(
    parameter int unsigned MS_CYCLES   = 50000,
    parameter int unsigned RST_LOW_MS  = 10,
    parameter int unsigned RST_WAIT_MS = 120,
    parameter int unsigned LCD_W       = 240,
    parameter int unsigned LCD_H       = 320
) (
    input  logic                 sys_clk_50MHz,
    input  logic                 sys_rst_n,
    output logic                 lcd_rst,
    output logic                 init_done,
`ifdef LCD_WIN_RESET_EN
    input  logic                 frame_start,
`endif
    lcd_init_sequencer_if.master lcd,
    lcd_init_sequencer_if.slave  client
);

    localparam int unsigned CYC_W    = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int unsigned MS_MAX0  = (RST_LOW_MS > RST_WAIT_MS) ? RST_LOW_MS : RST_WAIT_MS;
    localparam int unsigned MS_MAX   = (MS_MAX0 > 120) ? MS_MAX0 : 120;
    localparam int unsigned MS_W     = $clog2(MS_MAX + 1);
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned LAST_IDX = 18;
    localparam int unsigned WIN_IDX  = 8;
    localparam int unsigned W_END    = LCD_W - 1;
    localparam int unsigned H_END    = LCD_H - 1;

    typedef enum logic [2:0] {
        ST_RST_LOW, ST_RST_WAIT, ST_SEND, ST_WAIT_ACK, ST_DELAY, ST_RUN
    } state_t;

    // Init list: bit8 = D/C, bits7:0 = byte
    function automatic logic [8:0] f_entry(input logic [IDX_W-1:0] idx);
        case (idx)
            5'd0:    f_entry = 9'h001;
            5'd1:    f_entry = 9'h011;
            5'd2:    f_entry = 9'h03A;
            5'd3:    f_entry = 9'h155;
            5'd4:    f_entry = 9'h036;
            5'd5:    f_entry = 9'h100;
            5'd6:    f_entry = 9'h021;
            5'd7:    f_entry = 9'h029;
            5'd8:    f_entry = 9'h02A;
            5'd9:    f_entry = 9'h100;
            5'd10:   f_entry = 9'h100;
            5'd11:   f_entry = {1'b1, 8'(W_END >> 8)};
            5'd12:   f_entry = {1'b1, 8'(W_END)};
            5'd13:   f_entry = 9'h02B;
            5'd14:   f_entry = 9'h100;
            5'd15:   f_entry = 9'h100;
            5'd16:   f_entry = {1'b1, 8'(H_END >> 8)};
            5'd17:   f_entry = {1'b1, 8'(H_END)};
            default: f_entry = 9'h02C;
        endcase
    endfunction

    // Post-command delay in ms, zero for entries without one
    function automatic logic [MS_W-1:0] f_delay(input logic [IDX_W-1:0] idx);
        case (idx)
            5'd0, 5'd1: f_delay = MS_W'(120);
            5'd7:       f_delay = MS_W'(20);
            default:    f_delay = '0;
        endcase
    endfunction

    state_t           r_state, w_state;
    logic [CYC_W-1:0] r_cyc, w_cyc;
    logic [MS_W-1:0]  r_ms, w_ms;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic             r_lcd_rst, w_lcd_rst;
    logic [8:0]       r_lcd_data, w_lcd_data;
    logic             r_lcd_en, w_lcd_en;
    logic             r_init_done, w_init_done;
    logic             w_tick;
    logic [CYC_W-1:0] w_cyc_cnt;
    logic [MS_W-1:0]  w_ms_cnt;
    logic [MS_W-1:0]  w_dly;
    logic             w_run;
`ifdef LCD_WIN_RESET_EN
    logic             r_fs_pend, w_fs_pend;
`endif

    assign w_tick    = (r_cyc == CYC_W'(MS_CYCLES - 1));
    assign w_cyc_cnt = w_tick ? '0 : r_cyc + CYC_W'(1);
    assign w_ms_cnt  = w_tick ? r_ms + MS_W'(1) : r_ms;
    assign w_dly     = f_delay(r_idx);

    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_RST_LOW;
            r_cyc       <= '0;
            r_ms        <= '0;
            r_idx       <= '0;
            r_lcd_rst   <= 1'b0;
            r_lcd_data  <= '0;
            r_lcd_en    <= 1'b0;
            r_init_done <= 1'b0;
`ifdef LCD_WIN_RESET_EN
            r_fs_pend   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_cyc       <= w_cyc;
            r_ms        <= w_ms;
            r_idx       <= w_idx;
            r_lcd_rst   <= w_lcd_rst;
            r_lcd_data  <= w_lcd_data;
            r_lcd_en    <= w_lcd_en;
            r_init_done <= w_init_done;
`ifdef LCD_WIN_RESET_EN
            r_fs_pend   <= w_fs_pend;
`endif
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cyc       = '0;
        w_ms        = '0;
        w_idx       = r_idx;
        w_lcd_rst   = r_lcd_rst;
        w_lcd_data  = r_lcd_data;
        w_lcd_en    = r_lcd_en;
        w_init_done = r_init_done;
`ifdef LCD_WIN_RESET_EN
        w_fs_pend   = r_fs_pend;
`endif
        case (r_state)
            ST_RST_LOW: begin
                w_cyc = w_cyc_cnt;
                w_ms  = w_ms_cnt;
                if (w_tick && r_ms == MS_W'(RST_LOW_MS - 1)) begin
                    w_state   = ST_RST_WAIT;
                    w_lcd_rst = 1'b1;
                    w_cyc     = '0;
                    w_ms      = '0;
                end
            end
            ST_RST_WAIT: begin
                w_cyc = w_cyc_cnt;
                w_ms  = w_ms_cnt;
                if (w_tick && r_ms == MS_W'(RST_WAIT_MS - 1)) begin
                    w_state = ST_SEND;
                    w_cyc   = '0;
                    w_ms    = '0;
                end
            end
            ST_SEND: begin
                w_lcd_data = f_entry(r_idx);
                w_lcd_en   = 1'b1;
                w_state    = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (lcd.wr_done) begin
                    w_lcd_en = 1'b0;
                    if (w_dly != '0) begin
                        w_state = ST_DELAY;
                    end else if (r_idx == IDX_W'(LAST_IDX)) begin
                        w_state     = ST_RUN;
                        w_init_done = 1'b1;
                    end else begin
                        w_idx   = r_idx + IDX_W'(1);
                        w_state = ST_SEND;
                    end
                end
            end
            ST_DELAY: begin
                w_cyc = w_cyc_cnt;
                w_ms  = w_ms_cnt;
                if (w_tick && r_ms == w_dly - MS_W'(1)) begin
                    w_idx   = r_idx + IDX_W'(1);
                    w_state = ST_SEND;
                    w_cyc   = '0;
                    w_ms    = '0;
                end
            end
            ST_RUN: begin
`ifdef LCD_WIN_RESET_EN
                // A request seen while the client is mid-write waits until client_en drops
                if ((frame_start || r_fs_pend) && !client.en) begin
                    w_idx     = IDX_W'(WIN_IDX);
                    w_state   = ST_SEND;
                    w_fs_pend = 1'b0;
                end else if (frame_start) begin
                    w_fs_pend = 1'b1;
                end
`endif
            end
            default: w_state = ST_RST_LOW;
        endcase
    end

    // Client owns the lcd_write port only while in RUN
    assign w_run          = (r_state == ST_RUN);
    assign lcd.data       = w_run ? client.data : r_lcd_data;
    assign lcd.en         = w_run ? client.en : r_lcd_en;
    assign client.wr_done = w_run & lcd.wr_done;
    assign lcd_rst        = r_lcd_rst;
    assign init_done      = r_init_done;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer with an lcd_write model that acks 20 cycles after en.
module tb_lcd_init_sequencer;

    logic clk;
    logic rst_n;
    logic lcd_rst;
    logic init_done;
`ifdef LCD_WIN_RESET_EN
    logic frame_start;
`endif
    int   cyc;
    int   n_checks;
    int   n_errors;

    lcd_init_sequencer_if lcd_if ();
    lcd_init_sequencer_if cl_if ();

    lcd_init_sequencer #(.MS_CYCLES(10)) dut (
        .sys_clk_50MHz (clk),
        .sys_rst_n     (rst_n),
        .lcd_rst       (lcd_rst),
        .init_done     (init_done),
`ifdef LCD_WIN_RESET_EN
        .frame_start   (frame_start),
`endif
        .lcd           (lcd_if),
        .client        (cl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_bytes [19] = '{
        9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100, 9'h021, 9'h029,
        9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
        9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // lcd_write model plus protocol monitors
    int         nbytes;
    logic [8:0] log_data [64];
    int         start_cyc [64];
    int         ack_cyc [64];
    int         busy_cnt;
    bit         busy, need_low, prev_en;
    logic [8:0] prev_data;
    int         stab_err, pre_err, cwd_err;

    initial begin
        stab_err = 0;
        pre_err  = 0;
        cwd_err  = 0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            nbytes         = 0;
            busy           = 0;
            need_low       = 0;
            prev_en        = 0;
            lcd_if.wr_done = 1'b0;
        end else begin
            if (!init_done && cl_if.wr_done) pre_err++;
            if (cl_if.wr_done && !lcd_if.wr_done) cwd_err++;
            if (lcd_if.en && prev_en && lcd_if.data !== prev_data) stab_err++;
            prev_en        = lcd_if.en;
            prev_data      = lcd_if.data;
            lcd_if.wr_done = 1'b0;
            if (busy) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    lcd_if.wr_done = 1'b1;
                    busy           = 0;
                    need_low       = 1;
                    if (nbytes > 0 && nbytes <= 64) ack_cyc[nbytes-1] = cyc;
                end
            end else if (need_low) begin
                if (!lcd_if.en) need_low = 0;
            end else if (lcd_if.en) begin
                busy     = 1;
                busy_cnt = 20;
                if (nbytes < 64) begin
                    log_data[nbytes]  = lcd_if.data;
                    start_cyc[nbytes] = cyc;
                end
                nbytes++;
            end
        end
    end

    task automatic wait_bytes(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && nbytes < n; k++) @(negedge clk);
        check_eq(tag, 32'(nbytes >= n), 32'd1);
    endtask

    task automatic wait_init_done(input int budget, output int when);
        when = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (init_done) begin
                when = cyc;
                break;
            end
        end
        check_eq("init_done_timeout", 32'(when >= 0), 32'd1);
    endtask

    // Release reset and confirm lcd_rst stays low for exactly 100 cycles
    task automatic release_and_check_rst(input string tag, output int rise);
        int rel;
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        rise  = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (lcd_rst) begin
                rise = cyc;
                break;
            end
        end
        check_eq(tag, 32'(rise - rel), 32'd100);
    endtask

    task automatic client_write(input logic [8:0] d, input string tag);
        bit got;
        @(negedge clk);
        cl_if.data = d;
        cl_if.en   = 1'b1;
        #1;
        check_eq({tag, "_data"}, 32'(lcd_if.data), 32'(d));
        check_eq({tag, "_en"}, 32'(lcd_if.en), 32'd1);
        got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (cl_if.wr_done) begin
                got = 1;
                check_eq({tag, "_fwd"}, 32'(cl_if.wr_done), 32'(lcd_if.wr_done));
                break;
            end
        end
        check_eq({tag, "_ack"}, 32'(got), 32'd1);
        cl_if.en = 1'b0;
    endtask

    initial begin
        int rise, done_at, nb0;
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        cl_if.en   = 1'b1;
        cl_if.data = 9'h1FF;
`ifdef LCD_WIN_RESET_EN
        frame_start = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_lcd_rst", 32'(lcd_rst), 32'd0);
        check_eq("rst_lcd_data", 32'(lcd_if.data), 32'd0);
        check_eq("rst_lcd_en", 32'(lcd_if.en), 32'd0);
        check_eq("rst_client_wr_done", 32'(cl_if.wr_done), 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'd0);

        // Full init with the client requesting early
        release_and_check_rst("rst_low_cycles", rise);
        wait_bytes(1, 2000, "first_byte_timeout");
        check_eq("first_en_delay", 32'((start_cyc[0] - rise) >= 1200 && (start_cyc[0] - rise) <= 1202), 32'd1);
        check_eq("first_byte", 32'(log_data[0]), 32'h001);
        wait_bytes(18, 6000, "init_bytes_timeout");
        cl_if.en = 1'b0;
        wait_init_done(500, done_at);
        repeat (5) @(negedge clk);
        check_eq("init_byte_count", 32'(nbytes), 32'd19);
        for (int i = 0; i < 19; i++)
            check_eq($sformatf("init_byte_%0d", i), 32'(log_data[i]), 32'(exp_bytes[i]));
        check_eq("init_done_after_ramwr", 32'(done_at - ack_cyc[18]), 32'd1);
        check_eq("swreset_delay", 32'((start_cyc[1] - ack_cyc[0]) >= 1200), 32'd1);
        check_eq("slpout_delay", 32'((start_cyc[2] - ack_cyc[1]) >= 1200), 32'd1);
        check_eq("dispon_delay", 32'((start_cyc[8] - ack_cyc[7]) >= 200), 32'd1);
        check_eq("pre_run_client_ack", 32'(pre_err), 32'd0);
        client_write(9'h1FF, "run_client");

        // Async reset from RUN
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_init_done", 32'(init_done), 32'd0);
        check_eq("async_rst_lcd_rst", 32'(lcd_rst), 32'd0);
        repeat (2) @(negedge clk);

        // Reset during the SLPOUT delay
        release_and_check_rst("rst_low_cycles_2", rise);
        wait_bytes(2, 3000, "slpout_timeout");
        repeat (100) @(negedge clk);
        check_eq("in_slpout_delay", 32'(nbytes), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("slpout_rst_lcd_rst", 32'(lcd_rst), 32'd0);
        check_eq("slpout_rst_lcd_data", 32'(lcd_if.data), 32'd0);
        check_eq("slpout_rst_lcd_en", 32'(lcd_if.en), 32'd0);
        repeat (2) @(negedge clk);

        release_and_check_rst("rst_low_cycles_3", rise);
        wait_bytes(19, 8000, "restart_timeout");
        check_eq("restart_first_byte", 32'(log_data[0]), 32'h001);
        wait_init_done(500, done_at);
        repeat (5) @(negedge clk);
        check_eq("restart_byte_count", 32'(nbytes), 32'd19);

`ifdef LCD_WIN_RESET_EN
        // Window re-issue with the client idle
        nb0 = nbytes;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_bytes(nb0 + 11, 1000, "reissue_timeout");
        repeat (25) @(negedge clk);
        check_eq("reissue_count", 32'(nbytes), 32'(nb0 + 11));
        for (int i = 0; i < 11; i++)
            check_eq($sformatf("reissue_byte_%0d", i), 32'(log_data[nb0+i]), 32'(exp_bytes[8+i]));
        check_eq("reissue_init_done", 32'(init_done), 32'd1);
        client_write(9'h1FF, "restored_client");

        // Request raised mid client write is deferred
        nb0 = nbytes;
        @(negedge clk);
        cl_if.data  = 9'h1FF;
        cl_if.en    = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int k = 0; k < 60 && !cl_if.wr_done; k++) begin
            @(negedge clk);
            #1;
        end
        check_eq("pending_client_ack", 32'(cl_if.wr_done), 32'd1);
        cl_if.en = 1'b0;
        wait_bytes(nb0 + 12, 1000, "pending_timeout");
        repeat (25) @(negedge clk);
        check_eq("pending_client_first", 32'(log_data[nb0]), 32'h1FF);
        check_eq("pending_window_start", 32'(log_data[nb0+1]), 32'h02A);
        check_eq("pending_window_end", 32'(log_data[nb0+11]), 32'h02C);
`else
        // RUN is terminal: nothing but client bytes appear
        nb0 = nbytes;
        client_write(9'h0AB, "terminal_client");
        repeat (100) @(negedge clk);
        check_eq("run_terminal", 32'(nbytes), 32'(nb0 + 1));
        check_eq("terminal_byte", 32'(log_data[nb0]), 32'h0AB);
`endif
        check_eq("data_stable_while_en", 32'(stab_err), 32'd0);
        check_eq("wr_done_forward", 32'(cwd_err), 32'd0);
        check_eq("no_client_ack_pre_run", 32'(pre_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
